// File: rtl/colour_pkg.sv
// rtl/colour_pkg.sv - shared types, colour constants and FSM states for the colour sequence player
package colour_pkg;

   typedef logic [1:0] quad_t;
   typedef logic [2:0] colour_t;

   typedef struct packed {
      quad_t   quad;
      colour_t colour;
   } seq_entry_t;

   localparam colour_t COLOUR_BLACK = 3'd0;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ON,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - VGA vsync synchroniser and rising-edge detector producing a one-cycle frame tick
module frame_tick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic vs,
   output logic frame_tick
);

   logic vs_meta;
   logic vs_sync;
   logic vs_prev;

   // Two-flop synchroniser, one history flop, registered edge pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_meta    <= 1'b0;
         vs_sync    <= 1'b0;
         vs_prev    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_meta    <= vs;
         vs_sync    <= vs_meta;
         vs_prev    <= vs_sync;
         frame_tick <= vs_sync & ~vs_prev;
      end
   end

endmodule

// File: rtl/colour_sequence_player.sv
// rtl/colour_sequence_player.sv - frame-locked playback of a (quadrant, colour) sequence; SEQ_PLAYER_SPEEDUP_EN shortens later steps
module colour_sequence_player
   import colour_pkg::*;
#(
   parameter int MAX_LEN       = 16,
   parameter int ON_FRAMES     = 30,
   parameter int GAP_FRAMES    = 10,
   parameter int MIN_ON_FRAMES = 6
) (
   input  logic                       CLOCK_50,
   input  logic                       RESET_N,
   input  logic                       VGA_VS,
   input  logic                       GameOver,
   input  logic                       seq_wr,
   input  logic [$clog2(MAX_LEN)-1:0] seq_wr_addr,
   input  logic [4:0]                 seq_wr_data,
   input  logic [$clog2(MAX_LEN):0]   seq_len,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(MAX_LEN)-1:0] step_idx,
   output logic [2:0]                 colourLocation [0:3]
);

   localparam int IDX_W   = $clog2(MAX_LEN);
   localparam int LEN_W   = IDX_W + 1;
   localparam int CNT_MAX = (ON_FRAMES > GAP_FRAMES) ? ON_FRAMES : GAP_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

`ifdef SEQ_PLAYER_SPEEDUP_EN
   localparam int SPEED_STEP = 2;
`else
   localparam int SPEED_STEP = 0;
`endif

   // Floor never exceeds ON_FRAMES, so a zero speed step always yields ON_FRAMES
   localparam int ON_FLOOR = (MIN_ON_FRAMES < ON_FRAMES) ? MIN_ON_FRAMES : ON_FRAMES;

   function automatic logic [CNT_W-1:0] on_last(input logic [IDX_W-1:0] k);
      int t;
      t = ON_FRAMES - SPEED_STEP * int'(k);
      if (t < ON_FLOOR)
         t = ON_FLOOR;
      return CNT_W'(t - 1);
   endfunction

   seq_entry_t       mem [0:MAX_LEN-1];

   state_t           state,     state_nxt;
   logic [CNT_W-1:0] frame_cnt, cnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [LEN_W-1:0] eff_len,   len_nxt;
   seq_entry_t       lit,       lit_nxt;
   logic             show,      show_nxt;
   logic             frame_tick;
   logic [IDX_W-1:0] idx_next_step;
   logic [LEN_W-1:0] start_len;

   frame_tick_sync u_frame_tick_sync (
      .clk        (CLOCK_50),
      .rst_n      (RESET_N),
      .vs         (VGA_VS),
      .frame_tick (frame_tick)
   );

   assign idx_next_step = step_idx + 1'b1;
   assign start_len     = (seq_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seq_len;

   // Sequence memory: writes only land while idle; contents are not reset
   always_ff @(posedge CLOCK_50) begin
      if (seq_wr && state == IDLE)
         mem[seq_wr_addr] <= seq_wr_data;
   end

   // State, counters and the currently lit step
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         frame_cnt <= '0;
         step_idx  <= '0;
         eff_len   <= '0;
         lit       <= '0;
         show      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= cnt_nxt;
         step_idx  <= idx_nxt;
         eff_len   <= len_nxt;
         lit       <= lit_nxt;
         show      <= show_nxt;
      end
   end

   // Next-state logic; every transition after ALIGN happens on a frame tick
   always_comb begin
      state_nxt = state;
      cnt_nxt   = frame_cnt;
      idx_nxt   = step_idx;
      len_nxt   = eff_len;
      lit_nxt   = lit;
      show_nxt  = show;

      case (state)
         IDLE: begin
            show_nxt = 1'b0;
            if (start) begin
               len_nxt   = start_len;
               idx_nxt   = '0;
               state_nxt = (start_len == '0) ? DONE : ALIGN;
            end
         end
         ALIGN: begin
            if (frame_tick) begin
               lit_nxt   = mem[step_idx];
               show_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ON;
            end
         end
         ON: begin
            if (frame_tick) begin
               if (frame_cnt == on_last(step_idx)) begin
                  cnt_nxt   = '0;
                  show_nxt  = 1'b0;
                  state_nxt = GAP;
               end else begin
                  cnt_nxt = frame_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            if (frame_tick) begin
               if (frame_cnt == CNT_W'(GAP_FRAMES - 1)) begin
                  cnt_nxt = '0;
                  if ({1'b0, step_idx} == eff_len - 1'b1) begin
                     state_nxt = DONE;
                  end else begin
                     idx_nxt   = idx_next_step;
                     lit_nxt   = mem[idx_next_step];
                     show_nxt  = 1'b1;
                     state_nxt = ON;
                  end
               end else begin
                  cnt_nxt = frame_cnt + 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            show_nxt  = 1'b0;
         end
      endcase

      if (GameOver) begin
         state_nxt = IDLE;
         show_nxt  = 1'b0;
      end
   end

   assign busy = (state == ALIGN) || (state == ON) || (state == GAP);
   assign done = (state == DONE);

   // Only the lit step's quadrant carries a colour; the others show black
   always_comb begin
      for (int q = 0; q < 4; q++)
         colourLocation[q] = (show && lit.quad == quad_t'(q)) ? lit.colour : COLOUR_BLACK;
   end

endmodule

// File: tb/tb_colour_sequence_player.sv
// tb/tb_colour_sequence_player.sv - self-checking bench for colour_sequence_player
module tb_colour_sequence_player;

   localparam int CLK_HALF      = 10;
   localparam int VS_P          = 20;
   localparam int MAX_LEN       = 16;
   localparam int ON_FRAMES     = 30;
   localparam int GAP_FRAMES    = 10;
   localparam int MIN_ON_FRAMES = 6;
   localparam int PLAY_BOUND    = 20000;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b0;
   logic       VGA_VS   = 1'b0;
   logic       GameOver = 1'b0;
   logic       seq_wr   = 1'b0;
   logic [3:0] seq_wr_addr = '0;
   logic [4:0] seq_wr_data = '0;
   logic [4:0] seq_len  = '0;
   logic       start    = 1'b0;
   logic       busy;
   logic       done;
   logic [3:0] step_idx;
   logic [2:0] colourLocation [0:3];

   int n_checks = 0;
   int n_pass   = 0;

   logic [4:0] exp_mem [0:15];

   int seg_val[$];
   int seg_len[$];
   int done_cyc;
   int first_lit_cyc;
   int max_idx;
   int busy_bad;
   int busy_at_done;

   typedef struct {
      int len;
      int exp_steps;
      int exp_max_idx;
      int exp_done_cyc;
   } play_vec_t;

   play_vec_t vt [4];

   colour_sequence_player #(
      .MAX_LEN       (MAX_LEN),
      .ON_FRAMES     (ON_FRAMES),
      .GAP_FRAMES    (GAP_FRAMES),
      .MIN_ON_FRAMES (MIN_ON_FRAMES)
   ) dut (
      .CLOCK_50       (CLOCK_50),
      .RESET_N        (RESET_N),
      .VGA_VS         (VGA_VS),
      .GameOver       (GameOver),
      .seq_wr         (seq_wr),
      .seq_wr_addr    (seq_wr_addr),
      .seq_wr_data    (seq_wr_data),
      .seq_len        (seq_len),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .step_idx       (step_idx),
      .colourLocation (colourLocation)
   );

   always #CLK_HALF CLOCK_50 = ~CLOCK_50;

   initial begin
      #3;
      forever begin
         VGA_VS = 1'b1;
         #(4 * 2 * CLK_HALF);
         VGA_VS = 1'b0;
         #((VS_P - 4) * 2 * CLK_HALF);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int on_t(input int k);
`ifdef SEQ_PLAYER_SPEEDUP_EN
      int v;
      v = ON_FRAMES - 2 * k;
      return (v < MIN_ON_FRAMES) ? MIN_ON_FRAMES : v;
`else
      return ON_FRAMES + 0 * k;
`endif
   endfunction

   // -1 blank, -2 more than one quadrant lit, else quad*8+colour
   function automatic int sample_val();
      int v;
      int n;
      v = -1;
      n = 0;
      for (int q = 0; q < 4; q++) begin
         if (colourLocation[q] != 3'd0) begin
            n++;
            v = q * 8 + int'(colourLocation[q]);
         end
      end
      if (n > 1)
         v = -2;
      return v;
   endfunction

   task automatic wr(input int a, input logic [4:0] d);
      @(negedge CLOCK_50);
      seq_wr      = 1'b1;
      seq_wr_addr = a[3:0];
      seq_wr_data = d;
      @(negedge CLOCK_50);
      seq_wr = 1'b0;
      exp_mem[a] = d;
   endtask

   task automatic play(input int len, input bit co_wr, input int co_addr,
                       input logic [4:0] co_data, input int inj_at);
      int  cur;
      int  prev;
      int  run;
      int  cyc;
      bit  got_done;
      seg_val.delete();
      seg_len.delete();
      done_cyc      = -1;
      first_lit_cyc = -1;
      max_idx       = 0;
      busy_bad      = 0;
      busy_at_done  = -1;
      @(negedge CLOCK_50);
      seq_len = len[4:0];
      start   = 1'b1;
      if (co_wr) begin
         seq_wr      = 1'b1;
         seq_wr_addr = co_addr[3:0];
         seq_wr_data = co_data;
         exp_mem[co_addr] = co_data;
      end
      @(negedge CLOCK_50);
      start  = 1'b0;
      seq_wr = 1'b0;
      prev = -99;
      run  = 0;
      cyc  = 0;
      got_done = 1'b0;
      while (!got_done && cyc < PLAY_BOUND) begin
         cyc++;
         if (done) begin
            got_done     = 1'b1;
            done_cyc     = cyc;
            busy_at_done = int'(busy);
         end else begin
            if (!busy)
               busy_bad++;
            if (int'(step_idx) > max_idx)
               max_idx = int'(step_idx);
            cur = sample_val();
            if (cur != -1 && first_lit_cyc < 0)
               first_lit_cyc = cyc;
            if (run == 0 || cur == prev) begin
               prev = cur;
               run++;
            end else begin
               seg_val.push_back(prev);
               seg_len.push_back(run);
               prev = cur;
               run  = 1;
            end
            if (cyc == inj_at) begin
               seq_wr      = 1'b1;
               seq_wr_addr = 4'd0;
               seq_wr_data = 5'b11_110;
               seq_len     = 5'd1;
               start       = 1'b1;
            end else begin
               seq_wr = 1'b0;
               start  = 1'b0;
            end
            @(negedge CLOCK_50);
         end
      end
      seq_wr = 1'b0;
      start  = 1'b0;
      if (run > 0) begin
         seg_val.push_back(prev);
         seg_len.push_back(run);
      end
      if (seg_val.size() > 0 && seg_val[0] == -1) begin
         void'(seg_val.pop_front());
         void'(seg_len.pop_front());
      end
      check("done_seen", int'(got_done), 1);
      check("busy_at_done", busy_at_done, 0);
      @(negedge CLOCK_50);
      check("done_single_pulse", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
   endtask

   task automatic verify(input string tag, input int n);
      int exp_total;
      exp_total = 0;
      check($sformatf("%s_segments", tag), seg_val.size(), 2 * n);
      check($sformatf("%s_busy_gaps", tag), busy_bad, 0);
      for (int k = 0; k < n; k++) begin
         if (2 * k + 1 < seg_val.size()) begin
            check($sformatf("%s_step%0d_colour", tag, k), seg_val[2 * k], int'(exp_mem[k]));
            check($sformatf("%s_step%0d_on_cycles", tag, k), seg_len[2 * k], on_t(k) * VS_P);
            check($sformatf("%s_step%0d_gap_blank", tag, k), seg_val[2 * k + 1], -1);
            check($sformatf("%s_step%0d_gap_cycles", tag, k), seg_len[2 * k + 1], GAP_FRAMES * VS_P);
         end
         exp_total += (on_t(k) + GAP_FRAMES) * VS_P;
      end
      if (n > 0)
         check($sformatf("%s_first_lit_to_done", tag), done_cyc - first_lit_cyc, exp_total);
      else
         check($sformatf("%s_never_lit", tag), first_lit_cyc, -1);
   endtask

   initial begin
      logic [4:0] d;

      vt[0] = '{3, 3, 2, -1};
      vt[1] = '{0, 0, 0, 1};
      vt[2] = '{20, 16, 15, -1};
      vt[3] = '{14, 14, 13, -1};

      #5;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_step_idx", int'(step_idx), 0);
      check("reset_colour", sample_val(), -1);
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b1;

      for (int i = 0; i < 16; i++) begin
         d = {2'(i % 4), 3'((i % 7) + 1)};
         wr(i, d);
      end
      wr(0, {2'd0, 3'd1});
      wr(1, {2'd2, 3'd4});
      wr(2, {2'd3, 3'd7});

      for (int i = 0; i < 4; i++) begin
         play(vt[i].len, 1'b0, 0, 5'd0, -1);
         verify($sformatf("vec%0d_len%0d", i, vt[i].len), vt[i].exp_steps);
         check($sformatf("vec%0d_max_step_idx", i), max_idx, vt[i].exp_max_idx);
         if (vt[i].exp_done_cyc >= 0)
            check($sformatf("vec%0d_done_latency", i), done_cyc, vt[i].exp_done_cyc);
      end

      // GameOver during step 1, then a start held off by GameOver
      @(negedge CLOCK_50);
      seq_len = 5'd3;
      start   = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         if (step_idx == 4'd1 && sample_val() >= 0)
            break;
         @(negedge CLOCK_50);
      end
      check("go_reached_step1_on", int'(step_idx == 4'd1 && sample_val() >= 0), 1);
      repeat (50) @(negedge CLOCK_50);
      GameOver = 1'b1;
      @(negedge CLOCK_50);
      check("go_colour_black", sample_val(), -1);
      check("go_busy", int'(busy), 0);
      check("go_done", int'(done), 0);
      seq_len = 5'd3;
      start   = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      begin
         int activity;
         activity = 0;
         for (int c = 0; c < 200; c++) begin
            if (busy || done || sample_val() != -1)
               activity++;
            @(negedge CLOCK_50);
         end
         check("go_start_ignored", activity, 0);
      end
      GameOver = 1'b0;
      @(negedge CLOCK_50);
      check("go_released_idle", int'(busy), 0);

      // start and write while busy must not disturb playback or memory
      play(3, 1'b0, 0, 5'd0, 500);
      verify("busy_inject", 3);
      play(3, 1'b0, 0, 5'd0, -1);
      verify("readback", 3);

      // write coincident with start in IDLE: the new entry is played
      play(2, 1'b1, 1, 5'b01_101, -1);
      verify("co_write", 2);

      // asynchronous reset in the middle of step 1's gap
      @(negedge CLOCK_50);
      seq_len = 5'd3;
      start   = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         if (step_idx == 4'd1 && busy && sample_val() == -1 && c > 900)
            break;
         @(negedge CLOCK_50);
      end
      check("rst_reached_gap", int'(step_idx == 4'd1 && busy && sample_val() == -1), 1);
      repeat (20) @(negedge CLOCK_50);
      #5;
      RESET_N = 1'b0;
      #1;
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_done", int'(done), 0);
      check("rst_async_step_idx", int'(step_idx), 0);
      check("rst_async_colour", sample_val(), -1);
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      check("rst_release_idle", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
